// File: rtl/psg_write_arbiter.sv
// psg_write_arbiter: shares the jt49 write port between the music player and the SFX engine.
// Music writes to SFX-owned channels are shadowed and replayed on release. PSG_ARB_STATS_EN adds drop_count.
module psg_write_arbiter #(
    parameter int WR_HOLD = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       mus_valid,
    input  logic [3:0] mus_reg,
    input  logic [7:0] mus_data,
    output logic       mus_ready,
    input  logic       sfx_valid,
    input  logic [3:0] sfx_reg,
    input  logic [7:0] sfx_data,
    output logic       sfx_ready,
    input  logic [2:0] sfx_own,
    output logic [3:0] psg_addr,
    output logic [7:0] psg_data,
    output logic       psg_wr
`ifdef PSG_ARB_STATS_EN
    ,
    output logic [7:0] drop_count
`endif
);

    localparam int CW = (WR_HOLD > 1) ? $clog2(WR_HOLD) : 1;
    localparam logic [CW-1:0] HOLD_LAST = CW'(WR_HOLD - 1);
    localparam logic [CW-1:0] HOLD_ONE  = CW'(1);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_WRITE = 1'b1
    } state_t;

    // Registers of each channel: A={0,1,8}, B={2,3,9}, C={4,5,10}.
    function automatic logic [15:0] chan_regs(input logic [2:0] ch);
        logic [15:0] m;
        m = 16'h0000;
        if (ch[0]) m = m | 16'h0103;
        else       m = m;
        if (ch[1]) m = m | 16'h020C;
        else       m = m;
        if (ch[2]) m = m | 16'h0430;
        else       m = m;
        return m;
    endfunction

    function automatic logic [7:0] mixer_mask(input logic [2:0] ch);
        logic [7:0] m;
        m = 8'h00;
        if (ch[0]) m = m | 8'h09;
        else       m = m;
        if (ch[1]) m = m | 8'h12;
        else       m = m;
        if (ch[2]) m = m | 8'h24;
        else       m = m;
        return m;
    endfunction

    function automatic logic reg_owned(input logic [3:0] r, input logic [2:0] own);
        logic [15:0] m;
        m = chan_regs(own);
        return m[r];
    endfunction

    function automatic logic [7:0] mix_merge(input logic [7:0] mus_v, input logic [7:0] sfx_v,
                                             input logic [7:0] m);
        return (mus_v & ~m) | (sfx_v & m);
    endfunction

    state_t        state_r;
    logic [CW-1:0] hold_cnt_r;
    logic [7:0]    shadow_r [16];
    logic [7:0]    sfx7_r;
    logic [15:0]   pending_r;
    logic [2:0]    own_q_r;

    logic [2:0]    rise_s;
    logic [2:0]    fall_s;
    logic [7:0]    mix_m_s;
    logic [15:0]   pend_eff_s;
    logic [15:0]   pend_next_s;
    logic          idle_s;
    logic          replay_go_s;
    logic          sfx_go_s;
    logic          mus_go_s;
    logic [3:0]    replay_idx_s;
    logic [7:0]    replay_data_s;
    logic          mus_fwd_s;
    logic          sfx_fwd_s;
    logic [7:0]    mus_out_s;
    logic [7:0]    sfx_out_s;

    assign rise_s  = sfx_own & ~own_q_r;
    assign fall_s  = ~sfx_own & own_q_r;
    assign mix_m_s = mixer_mask(sfx_own);

    // A channel re-claimed before its replay no longer needs it; reg 7 stays pending.
    assign pend_eff_s  = pending_r & ~chan_regs(rise_s);
    assign idle_s      = (state_r == ST_IDLE) && !reset;
    assign replay_go_s = idle_s && (pend_eff_s != 16'h0000);
    assign sfx_go_s    = idle_s && (pend_eff_s == 16'h0000) && sfx_valid;
    assign mus_go_s    = idle_s && (pend_eff_s == 16'h0000) && !sfx_valid && mus_valid;
    assign sfx_ready   = sfx_go_s;
    assign mus_ready   = mus_go_s;

    assign pend_next_s = (pend_eff_s & ~(replay_go_s ? (16'h0001 << replay_idx_s) : 16'h0000))
                       | chan_regs(fall_s)
                       | ((fall_s != 3'b000) ? 16'h0080 : 16'h0000)
                       | (((own_q_r != 3'b000) && (sfx_own == 3'b000)) ? 16'h0040 : 16'h0000);

    assign mus_fwd_s = !(reg_owned(mus_reg, sfx_own) || ((mus_reg == 4'd6) && (sfx_own != 3'b000)));
    assign sfx_fwd_s = (sfx_reg == 4'd7) || reg_owned(sfx_reg, sfx_own)
                     || ((sfx_reg == 4'd6) && (sfx_own != 3'b000));
    assign mus_out_s = (mus_reg == 4'd7) ? mix_merge(mus_data, sfx7_r, mix_m_s) : mus_data;
    assign sfx_out_s = (sfx_reg == 4'd7) ? mix_merge(shadow_r[7], sfx_data, mix_m_s) : sfx_data;

    // Lowest pending register index wins the replay slot.
    always_comb begin
        replay_idx_s = 4'd0;
        for (int i = 15; i >= 0; i--) begin
            if (pend_eff_s[i]) replay_idx_s = 4'(i);
            else               replay_idx_s = replay_idx_s;
        end
    end

    assign replay_data_s = (replay_idx_s == 4'd7) ? mix_merge(shadow_r[7], sfx7_r, mix_m_s)
                                                  : shadow_r[replay_idx_s];

    // Shadow state, ownership tracking, replay mask and the write-strobe FSM.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r    <= ST_IDLE;
            hold_cnt_r <= '0;
            sfx7_r     <= 8'd0;
            pending_r  <= 16'h0000;
            own_q_r    <= 3'b000;
            psg_addr   <= 4'd0;
            psg_data   <= 8'd0;
            psg_wr     <= 1'b0;
            for (int i = 0; i < 16; i++) shadow_r[i] <= 8'd0;
        end else begin
            own_q_r   <= sfx_own;
            pending_r <= pend_next_s;
            if (mus_go_s) shadow_r[mus_reg] <= mus_data;
            if (sfx_go_s && (sfx_reg == 4'd7)) sfx7_r <= sfx_data;
            case (state_r)
                ST_IDLE: begin
                    if (replay_go_s) begin
                        psg_addr   <= replay_idx_s;
                        psg_data   <= replay_data_s;
                        psg_wr     <= 1'b1;
                        hold_cnt_r <= '0;
                        state_r    <= ST_WRITE;
                    end else if (sfx_go_s && sfx_fwd_s) begin
                        psg_addr   <= sfx_reg;
                        psg_data   <= sfx_out_s;
                        psg_wr     <= 1'b1;
                        hold_cnt_r <= '0;
                        state_r    <= ST_WRITE;
                    end else if (mus_go_s && mus_fwd_s) begin
                        psg_addr   <= mus_reg;
                        psg_data   <= mus_out_s;
                        psg_wr     <= 1'b1;
                        hold_cnt_r <= '0;
                        state_r    <= ST_WRITE;
                    end else begin
                        psg_wr  <= 1'b0;
                        state_r <= ST_IDLE;
                    end
                end
                ST_WRITE: begin
                    if (hold_cnt_r == HOLD_LAST) begin
                        psg_wr  <= 1'b0;
                        state_r <= ST_IDLE;
                    end else begin
                        hold_cnt_r <= hold_cnt_r + HOLD_ONE;
                    end
                end
                default: begin
                    psg_wr  <= 1'b0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef PSG_ARB_STATS_EN
    logic drop_s;
    assign drop_s = (sfx_go_s && !sfx_fwd_s) || (mus_go_s && !mus_fwd_s);

    // Saturating count of accepted writes that never reached the PSG.
    always_ff @(posedge clk) begin
        if (reset) begin
            drop_count <= 8'd0;
        end else if (drop_s && (drop_count != 8'hFF)) begin
            drop_count <= drop_count + 8'd1;
        end else begin
            drop_count <= drop_count;
        end
    end
`endif

endmodule

// File: tb/tb_psg_write_arbiter.sv
// Self-checking bench for psg_write_arbiter: cycle model of the arbitration rules plus
// literal checks of the PSG write stream.
module tb_psg_write_arbiter;

    localparam int WR_HOLD = 2;

    logic       clk = 1'b0;
    logic       reset;
    logic       mus_valid;
    logic [3:0] mus_reg;
    logic [7:0] mus_data;
    logic       mus_ready;
    logic       sfx_valid;
    logic [3:0] sfx_reg;
    logic [7:0] sfx_data;
    logic       sfx_ready;
    logic [2:0] sfx_own;
    logic [3:0] psg_addr;
    logic [7:0] psg_data;
    logic       psg_wr;
`ifdef PSG_ARB_STATS_EN
    logic [7:0] drop_count;
`endif

    psg_write_arbiter #(.WR_HOLD(WR_HOLD)) dut (
        .clk       (clk),
        .reset     (reset),
        .mus_valid (mus_valid),
        .mus_reg   (mus_reg),
        .mus_data  (mus_data),
        .mus_ready (mus_ready),
        .sfx_valid (sfx_valid),
        .sfx_reg   (sfx_reg),
        .sfx_data  (sfx_data),
        .sfx_ready (sfx_ready),
        .sfx_own   (sfx_own),
        .psg_addr  (psg_addr),
        .psg_data  (psg_data),
        .psg_wr    (psg_wr)
`ifdef PSG_ARB_STATS_EN
        ,
        .drop_count(drop_count)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got 0x%0h expected 0x%0h", name, cyc, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    bit [7:0]  m_shadow [16];
    bit [7:0]  m_sfx7;
    bit [15:0] m_pend;
    int        m_busy;
    bit [3:0]  m_addr;
    bit [7:0]  m_data;
    bit [2:0]  m_prev;
    bit        m_init = 1'b0;
    int        m_drops;

    function automatic int owner_of(input int r);
        if (r < 6) return r / 2;
        if (r >= 8 && r <= 10) return r - 8;
        return -1;
    endfunction

    function automatic bit owned(input int r, input bit [2:0] own);
        int o;
        o = owner_of(r);
        return (o >= 0) && own[o];
    endfunction

    function automatic bit [7:0] mix_of(input bit [2:0] own);
        bit [7:0] m;
        m = 8'h00;
        for (int ch = 0; ch < 3; ch++) if (own[ch]) m = m | (8'h09 << ch);
        return m;
    endfunction

    function automatic bit [7:0] merged(input bit [7:0] mus_v, input bit [7:0] sfx_v, input bit [2:0] own);
        return (mus_v & ~mix_of(own)) | (sfx_v & mix_of(own));
    endfunction

    function automatic bit [15:0] eff_pending(input bit [2:0] own);
        bit [15:0] p;
        bit [2:0]  rise;
        p = m_pend;
        rise = own & ~m_prev;
        for (int r = 0; r < 16; r++) if (owned(r, rise)) p[r] = 1'b0;
        return p;
    endfunction

    task automatic issue(input int r, input bit [7:0] d);
        m_addr = 4'(r);
        m_data = d;
        m_busy = WR_HOLD;
    endtask

    task automatic drop();
        if (m_drops < 255) m_drops++;
    endtask

    task automatic model_step();
        bit [2:0] rise;
        bit [2:0] fall;
        int       r;
        if (reset) begin
            for (int i = 0; i < 16; i++) m_shadow[i] = 8'h00;
            m_sfx7 = 8'h00; m_pend = 16'h0000; m_busy = 0;
            m_addr = 4'h0; m_data = 8'h00; m_prev = 3'b000; m_drops = 0;
            m_init = 1'b1;
        end else if (m_init) begin
            rise = sfx_own & ~m_prev;
            fall = ~sfx_own & m_prev;
            for (int i = 0; i < 16; i++) if (owned(i, rise)) m_pend[i] = 1'b0;
            if (m_busy == 0) begin
                if (m_pend != 16'h0000) begin
                    r = 0;
                    while (!m_pend[r]) r++;
                    m_pend[r] = 1'b0;
                    issue(r, (r == 7) ? merged(m_shadow[7], m_sfx7, sfx_own) : m_shadow[r]);
                end else if (sfx_valid) begin
                    if (sfx_reg == 4'd7) begin
                        m_sfx7 = sfx_data;
                        issue(7, merged(m_shadow[7], m_sfx7, sfx_own));
                    end else if (owned(sfx_reg, sfx_own) || (sfx_reg == 4'd6 && sfx_own != 3'b000)) begin
                        issue(sfx_reg, sfx_data);
                    end else begin
                        drop();
                    end
                end else if (mus_valid) begin
                    m_shadow[mus_reg] = mus_data;
                    if (owned(mus_reg, sfx_own) || (mus_reg == 4'd6 && sfx_own != 3'b000)) drop();
                    else issue(mus_reg, (mus_reg == 4'd7) ? merged(mus_data, m_sfx7, sfx_own) : mus_data);
                end
            end else begin
                m_busy--;
            end
            for (int i = 0; i < 16; i++) if (owned(i, fall)) m_pend[i] = 1'b1;
            if (fall != 3'b000) m_pend[7] = 1'b1;
            if (m_prev != 3'b000 && sfx_own == 3'b000) m_pend[6] = 1'b1;
            m_prev = sfx_own;
        end
    endtask

    // Compare just before each active edge, then advance the model with the same inputs.
    initial begin
        bit        idle;
        bit [15:0] pe;
        forever begin
            @(negedge clk);
            #3;
            if (m_init) begin
                pe   = eff_pending(sfx_own);
                idle = (m_busy == 0) && !reset;
                chk("psg_wr", psg_wr, (m_busy > 0));
                chk("sfx_ready", sfx_ready, idle && pe == 16'h0000 && sfx_valid);
                chk("mus_ready", mus_ready, idle && pe == 16'h0000 && !sfx_valid && mus_valid);
                if (m_busy > 0) begin
                    chk("psg_addr", psg_addr, m_addr);
                    chk("psg_data", psg_data, m_data);
                end
`ifdef PSG_ARB_STATS_EN
                chk("drop_count", drop_count, m_drops);
`endif
            end
            model_step();
        end
    end

    // ---------------- PSG write log ----------------
    logic [11:0] wlog[$];
    initial begin
        logic prev_wr;
        prev_wr = 1'b0;
        forever begin
            @(negedge clk);
            if (psg_wr === 1'b1 && prev_wr !== 1'b1) wlog.push_back({psg_addr, psg_data});
            prev_wr = psg_wr;
        end
    end

    task automatic check_log(input string name, input int idx, input logic [3:0] a, input logic [7:0] d);
        if (idx >= wlog.size()) begin
            checks++;
            errors++;
            $display("FAIL %s: log entry %0d missing (log size %0d)", name, idx, wlog.size());
        end else begin
            chk(name, wlog[idx], {a, d});
        end
    endtask

    // ---------------- stimulus ----------------
    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic mus_write(input logic [3:0] r, input logic [7:0] d);
        bit got;
        got = 1'b0;
        mus_valid = 1'b1; mus_reg = r; mus_data = d;
        for (int i = 0; i < 200 && !got; i++) begin
            #3;
            got = (mus_ready === 1'b1);
            @(negedge clk);
        end
        mus_valid = 1'b0;
        chk("mus_accept", got, 1'b1);
    endtask

    task automatic sfx_write(input logic [3:0] r, input logic [7:0] d);
        bit got;
        got = 1'b0;
        sfx_valid = 1'b1; sfx_reg = r; sfx_data = d;
        for (int i = 0; i < 200 && !got; i++) begin
            #3;
            got = (sfx_ready === 1'b1);
            @(negedge clk);
        end
        sfx_valid = 1'b0;
        chk("sfx_accept", got, 1'b1);
    endtask

    logic [11:0] t5_exp [11];
    logic [11:0] zero_exp [5];

    initial begin
        int s_cyc;
        int m_cyc;
        int base;

        reset = 1'b1; mus_valid = 1'b0; mus_reg = 4'd0; mus_data = 8'd0;
        sfx_valid = 1'b0; sfx_reg = 4'd0; sfx_data = 8'd0; sfx_own = 3'b000;
        tick(3);
        reset = 1'b0;
        chk("reset_psg_wr", psg_wr, 1'b0);
        chk("reset_psg_addr", psg_addr, 4'd0);
        chk("reset_psg_data", psg_data, 8'd0);
        tick(2);

        // 1: plain music write
        mus_write(4'd0, 8'h5A);
        tick(4);
        check_log("t1_write", 0, 4'd0, 8'h5A);
        chk("t1_log_size", wlog.size(), 1);

        // 2: music to owned channel is shadowed; SFX to it forwards
        sfx_own = 3'b100;
        tick(1);
        mus_write(4'd10, 8'h0F);
        tick(3);
        chk("t2_no_mus_write", wlog.size(), 1);
        sfx_write(4'd10, 8'h08);
        tick(4);
        check_log("t2_sfx_write", 1, 4'd10, 8'h08);

        // 3: release C replays its shadows with music held off
        sfx_own = 3'b000;
        tick(1);
        mus_write(4'd1, 8'h11);
        tick(4);
        check_log("t3_r4", 2, 4'd4, 8'h00);
        check_log("t3_r5", 3, 4'd5, 8'h00);
        check_log("t3_r6", 4, 4'd6, 8'h00);
        check_log("t3_r7", 5, 4'd7, 8'h00);
        check_log("t3_r10", 6, 4'd10, 8'h0F);
        check_log("t3_mus_after", 7, 4'd1, 8'h11);

        // 4: mixer merge
        mus_write(4'd7, 8'h38);
        tick(3);
        check_log("t4_mus7", 8, 4'd7, 8'h38);
        sfx_own = 3'b001;
        tick(1);
        sfx_write(4'd7, 8'h36);
        tick(3);
        check_log("t4_merged7", 9, 4'd7, 8'h30);
        sfx_own = 3'b000;
        tick(16);
        check_log("t4_rel_r0", 10, 4'd0, 8'h5A);
        check_log("t4_rel_r1", 11, 4'd1, 8'h11);
        check_log("t4_rel_r6", 12, 4'd6, 8'h00);
        check_log("t4_rel_r7", 13, 4'd7, 8'h38);
        check_log("t4_rel_r8", 14, 4'd8, 8'h00);

        // 5: simultaneous requests, SFX first; music reg6 dropped three cycles later
        sfx_own = 3'b111;
        tick(2);
        mus_valid = 1'b1; mus_reg = 4'd6; mus_data = 8'h01;
        sfx_valid = 1'b1; sfx_reg = 4'd0; sfx_data = 8'h77;
        s_cyc = -1; m_cyc = -1;
        for (int i = 0; i < 200 && (s_cyc < 0 || m_cyc < 0); i++) begin
            #3;
            if (sfx_ready === 1'b1 && s_cyc < 0) s_cyc = cyc;
            if (mus_ready === 1'b1 && m_cyc < 0) m_cyc = cyc;
            @(negedge clk);
            if (s_cyc >= 0) sfx_valid = 1'b0;
            if (m_cyc >= 0) mus_valid = 1'b0;
        end
        mus_valid = 1'b0; sfx_valid = 1'b0;
        chk("t5_sfx_seen", (s_cyc >= 0), 1'b1);
        chk("t5_mus_delay", m_cyc - s_cyc, 3);
        tick(3);
        check_log("t5_sfx0", 15, 4'd0, 8'h77);
        chk("t5_log_size", wlog.size(), 16);
        sfx_own = 3'b000;
        tick(40);
        t5_exp = '{12'h05A, 12'h111, 12'h200, 12'h300, 12'h400, 12'h500,
                   12'h601, 12'h738, 12'h800, 12'h900, 12'hA0F};
        for (int i = 0; i < 11; i++) check_log("t5_replay", 16 + i, t5_exp[i][11:8], t5_exp[i][7:0]);

        // 6: reset on the first strobe cycle clears everything
        sfx_own = 3'b010;
        tick(1);
        mus_write(4'd0, 8'h42);
        chk("t6_first_wr", psg_wr, 1'b1);
        reset = 1'b1;
        sfx_own = 3'b000;
        tick(1);
        chk("t6_wr_dropped", psg_wr, 1'b0);
        reset = 1'b0;
        base = wlog.size();
        chk("t6_log_size", base, 28);
        tick(10);
        chk("t6_no_replay", wlog.size(), base);
`ifdef PSG_ARB_STATS_EN
        chk("t6_drop_count", drop_count, 8'd0);
`endif
        sfx_own = 3'b001;
        tick(2);
        sfx_own = 3'b000;
        tick(16);
        zero_exp = '{12'h000, 12'h100, 12'h600, 12'h700, 12'h800};
        for (int i = 0; i < 5; i++) check_log("t6_zero_replay", base + i, zero_exp[i][11:8], zero_exp[i][7:0]);
        chk("t6_final_size", wlog.size(), base + 5);

        tick(2);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
